// File: rtl/hazard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_pkg : shared types for the decode-stage interlock controller.
// Rev 1.0
// ----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_W    = 3;
  localparam int N_STAGES = 3;
  localparam int EX_IDX   = 0;
  localparam int MEM_IDX  = 1;
  localparam int WB_IDX   = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic             ld;
  } inflight_t;

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_match : compares one in-flight write against the decode Rs/Rt selects.
// Rev 1.0
// ----------------------------------------------------------------------------
module hazard_match
  import hazard_pkg::*;
(
  input  inflight_t        entry_i,
  input  logic [REG_W-1:0] rs_sel_i,
  input  logic             rs_chk_i,
  input  logic [REG_W-1:0] rt_sel_i,
  input  logic             rt_chk_i,
  output logic             rs_hit_o,
  output logic             rt_hit_o
);

  assign rs_hit_o = entry_i.vld & rs_chk_i & (entry_i.dest == rs_sel_i);
  assign rt_hit_o = entry_i.vld & rt_chk_i & (entry_i.dest == rt_sel_i);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_ctrl : decode-stage interlock (stall / bubble / flush / halt drain).
// Optional macro FORWARD_EN selects the forwarding-aware hazard rule. Rev 1.0
// ----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_sel_i,
  input  logic             id_rs_used_i,
  input  logic [REG_W-1:0] id_rt_sel_i,
  input  logic             id_rt_used_i,
  input  logic             id_reg_write_i,
  input  logic [REG_W-1:0] id_dest_i,
  input  logic             id_mem_read_i,
  input  logic             id_branch_i,
  input  logic             id_jump_taken_i,
  input  logic             id_halt_i,
  input  logic             mem_stall_i,
  output logic             stall_fetch_o,
  output logic             stall_decode_o,
  output logic             bubble_ex_o,
  output logic             flush_fetch_o,
  output logic             halted_o,
  output logic             err_o
);

  state_e           state_q;
  inflight_t        tbl_q [N_STAGES];
  inflight_t        ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, err_q;

  logic       rs_chk, rt_chk, haz, run, issue, drained, err_set;
  logic       stall_fetch, stall_decode, bubble_ex, flush_fetch;
  logic [1:0] rs_hit, rt_hit;
  logic       unused_ok;

  // Branches consume Rs in decode even when the ALU does not read it.
  assign rs_chk = id_valid_i & (id_rs_used_i | id_branch_i);
  assign rt_chk = id_valid_i & id_rt_used_i;

  for (genvar s = 0; s < 2; s++) begin : g_match
    hazard_match u_match (
      .entry_i  (tbl_q[s]),
      .rs_sel_i (id_rs_sel_i),
      .rs_chk_i (rs_chk),
      .rt_sel_i (id_rt_sel_i),
      .rt_chk_i (rt_chk),
      .rs_hit_o (rs_hit[s]),
      .rt_hit_o (rt_hit[s])
    );
  end

`ifdef FORWARD_EN
  assign haz = (tbl_q[EX_IDX].ld & (rs_hit[EX_IDX] | rt_hit[EX_IDX]))
             | (id_branch_i & (rs_hit[EX_IDX] | (tbl_q[MEM_IDX].ld & rs_hit[MEM_IDX])));
`else
  assign haz = rs_hit[EX_IDX] | rt_hit[EX_IDX] | rs_hit[MEM_IDX] | rt_hit[MEM_IDX];
`endif

  assign unused_ok = ^{tbl_q[WB_IDX].dest, tbl_q[WB_IDX].ld, tbl_q[MEM_IDX].ld, rt_hit[MEM_IDX]};

  assign run          = (state_q == ST_RUN);
  assign issue        = run & id_valid_i & ~haz & ~mem_stall_i;
  assign drained      = ~tbl_q[EX_IDX].vld & ~tbl_q[MEM_IDX].vld & ~tbl_q[WB_IDX].vld;
  assign stall_fetch  = haz | mem_stall_i | ~run;
  assign stall_decode = haz | mem_stall_i;
  assign bubble_ex    = (haz & ~mem_stall_i) | (state_q == ST_DRAIN);
  assign flush_fetch  = run & id_valid_i & id_jump_taken_i & ~haz & ~mem_stall_i;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.vld  = id_reg_write_i;
      ex_d.dest = id_dest_i;
      ex_d.ld   = id_mem_read_i;
    end
    cnt_d = '0;
    if (run && stall_fetch) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign err_set = (cnt_d >= CNT_W'(STALL_LIMIT))
                 | (id_valid_i & id_halt_i & id_jump_taken_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      for (int i = 0; i < N_STAGES; i++) tbl_q[i] <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (!mem_stall_i) begin
        tbl_q[WB_IDX]  <= tbl_q[MEM_IDX];
        tbl_q[MEM_IDX] <= tbl_q[EX_IDX];
        tbl_q[EX_IDX]  <= ex_d;
      end
      cnt_q <= cnt_d;
      if (err_set) err_q <= 1'b1;
      case (state_q)
        ST_RUN:    if (issue && id_halt_i) state_q <= ST_DRAIN;
        ST_DRAIN:  if (drained) begin
                     state_q  <= ST_HALTED;
                     halted_q <= 1'b1;
                   end
        ST_HALTED: halted_q <= 1'b1;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  // Combinational controls are forced low while reset is held.
  assign stall_fetch_o  = rst_ni & stall_fetch;
  assign stall_decode_o = rst_ni & stall_decode;
  assign bubble_ex_o    = rst_ni & bubble_ex;
  assign flush_fetch_o  = rst_ni & flush_fetch;
  assign halted_o       = halted_q;
  assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_ctrl : scoreboard bench for hazard_ctrl (honours FORWARD_EN).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [2:0] rs;
    logic       rsu;
    logic [2:0] rt;
    logic       rtu;
    logic       rw;
    logic [2:0] dst;
    logic       ld;
    logic       br;
    logic       jt;
    logic       hlt;
    logic       ms;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [5:0] e;
  } vec_t;

  // {stall_fetch, stall_decode, bubble_ex, flush_fetch, halted, err}
  localparam logic [5:0] E_OK  = 6'b000000;
  localparam logic [5:0] E_HAZ = 6'b111000;
  localparam logic [5:0] E_FL  = 6'b000100;
  localparam logic [5:0] E_MS  = 6'b110000;
  localparam logic [5:0] E_DR  = 6'b101000;
  localparam logic [5:0] E_HL  = 6'b100010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
  logic       id_branch, id_jump_taken, id_halt, mem_stall;
  logic [2:0] id_rs_sel, id_rt_sel, id_dest;
  logic       stall_fetch, stall_decode, bubble_ex, flush_fetch, halted, err;
  logic [5:0] outs;

  int         checks = 0;
  int         failures = 0;
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .id_valid_i      (id_valid),
    .id_rs_sel_i     (id_rs_sel),
    .id_rs_used_i    (id_rs_used),
    .id_rt_sel_i     (id_rt_sel),
    .id_rt_used_i    (id_rt_used),
    .id_reg_write_i  (id_reg_write),
    .id_dest_i       (id_dest),
    .id_mem_read_i   (id_mem_read),
    .id_branch_i     (id_branch),
    .id_jump_taken_i (id_jump_taken),
    .id_halt_i       (id_halt),
    .mem_stall_i     (mem_stall),
    .stall_fetch_o   (stall_fetch),
    .stall_decode_o  (stall_decode),
    .bubble_ex_o     (bubble_ex),
    .flush_fetch_o   (flush_fetch),
    .halted_o        (halted),
    .err_o           (err)
  );

  assign outs = {stall_fetch, stall_decode, bubble_ex, flush_fetch, halted, err};

  function automatic stim_t s_nop();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t s_alu(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    stim_t s = '0;
    s.v = 1'b1; s.rs = a; s.rsu = 1'b1; s.rt = b; s.rtu = 1'b1; s.rw = 1'b1; s.dst = d;
    return s;
  endfunction

  function automatic stim_t s_ld(input logic [2:0] d, input logic [2:0] a);
    stim_t s = '0;
    s.v = 1'b1; s.rs = a; s.rsu = 1'b1; s.rw = 1'b1; s.dst = d; s.ld = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_br(input logic [2:0] a, input logic tk);
    stim_t s = '0;
    s.v = 1'b1; s.rs = a; s.rsu = 1'b1; s.br = 1'b1; s.jt = tk;
    return s;
  endfunction

  function automatic stim_t s_jmp();
    stim_t s = '0;
    s.v = 1'b1; s.jt = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_halt();
    stim_t s = '0;
    s.v = 1'b1; s.hlt = 1'b1;
    return s;
  endfunction

  function automatic stim_t with_ms(input stim_t s);
    stim_t r = s;
    r.ms = 1'b1;
    return r;
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.v;  id_rs_sel = s.rs; id_rs_used = s.rsu;
    id_rt_sel = s.rt; id_rt_used = s.rtu; id_reg_write = s.rw;
    id_dest = s.dst; id_mem_read = s.ld; id_branch = s.br;
    id_jump_taken = s.jt; id_halt = s.hlt; mem_stall = s.ms;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(s_nop());
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s;
    logic [5:0] want;
    s = with_ms(s_jmp());
    s.hlt = 1'b1;
    rst_n = 1'b0;
    apply(s);
    exp_q.push_back(E_OK);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (outs !== want) begin
      failures++;
      $display("FAIL reset_held got=%b expected=%b", outs, want);
    end
    @(posedge clk); #1;
    apply(s_nop());
    rst_n = 1'b1;
    exp_q.push_back(E_OK);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (outs !== want) begin
      failures++;
      $display("FAIL reset_release got=%b expected=%b", outs, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    vec_t q [$];
    logic [5:0] want;
    do_reset();
    q.push_back('{s_ld(3'd1, 3'd0), E_OK});
    q.push_back('{s_alu(3'd2, 3'd1, 3'd3), E_HAZ});
`ifndef FORWARD_EN
    q.push_back('{s_alu(3'd2, 3'd1, 3'd3), E_HAZ});
`endif
    q.push_back('{s_alu(3'd2, 3'd1, 3'd3), E_OK});
    q.push_back('{s_nop(), E_OK});
    foreach (q[i]) begin
      apply(q[i].s);
      exp_q.push_back(q[i].e);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL load_use step=%0d got=%b expected=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_dep();
    vec_t q [$];
    logic [5:0] want;
    stim_t nouse;
    do_reset();
    q.push_back('{s_alu(3'd1, 3'd2, 3'd3), E_OK});
`ifndef FORWARD_EN
    q.push_back('{s_alu(3'd4, 3'd1, 3'd1), E_HAZ});
    q.push_back('{s_alu(3'd4, 3'd1, 3'd1), E_HAZ});
`endif
    q.push_back('{s_alu(3'd4, 3'd1, 3'd1), E_OK});
    q.push_back('{s_alu(3'd1, 3'd2, 3'd3), E_OK});
    q.push_back('{s_alu(3'd6, 3'd5, 3'd5), E_OK});
    q.push_back('{s_nop(), E_OK});
    q.push_back('{s_nop(), E_OK});
    q.push_back('{s_nop(), E_OK});
    // r7 producer, then a reader whose selects match but are not used
    nouse = s_alu(3'd0, 3'd7, 3'd7);
    nouse.rsu = 1'b0;
    nouse.rtu = 1'b0;
    q.push_back('{s_alu(3'd7, 3'd0, 3'd0), E_OK});
    q.push_back('{nouse, E_OK});
`ifndef FORWARD_EN
    q.push_back('{s_alu(3'd3, 3'd4, 3'd7), E_HAZ});
`endif
    q.push_back('{s_alu(3'd3, 3'd4, 3'd7), E_OK});
    q.push_back('{s_nop(), E_OK});
    foreach (q[i]) begin
      apply(q[i].s);
      exp_q.push_back(q[i].e);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL alu_dep step=%0d got=%b expected=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    vec_t q [$];
    logic [5:0] want;
    do_reset();
    q.push_back('{s_alu(3'd1, 3'd2, 3'd3), E_OK});
    q.push_back('{s_br(3'd1, 1'b1), E_HAZ});
`ifndef FORWARD_EN
    q.push_back('{s_br(3'd1, 1'b1), E_HAZ});
`endif
    q.push_back('{s_br(3'd1, 1'b1), E_FL});
    q.push_back('{s_nop(), E_OK});
    q.push_back('{s_nop(), E_OK});
    q.push_back('{s_ld(3'd1, 3'd0), E_OK});
    q.push_back('{s_br(3'd1, 1'b1), E_HAZ});
    q.push_back('{s_br(3'd1, 1'b1), E_HAZ});
    q.push_back('{s_br(3'd1, 1'b1), E_FL});
    q.push_back('{s_nop(), E_OK});
    foreach (q[i]) begin
      apply(q[i].s);
      exp_q.push_back(q[i].e);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL branch step=%0d got=%b expected=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    vec_t q [$];
    logic [5:0] want;
    do_reset();
    q.push_back('{s_jmp(), E_FL});
    q.push_back('{s_nop(), E_OK});
    q.push_back('{with_ms(s_jmp()), E_MS});
    q.push_back('{s_jmp(), E_FL});
    q.push_back('{s_nop(), E_OK});
    q.push_back('{s_alu(3'd3, 3'd2, 3'd2), E_OK});
    q.push_back('{s_br(3'd3, 1'b1), E_HAZ});
`ifndef FORWARD_EN
    q.push_back('{s_br(3'd3, 1'b1), E_HAZ});
`endif
    q.push_back('{s_br(3'd3, 1'b1), E_FL});
    q.push_back('{s_nop(), E_OK});
    foreach (q[i]) begin
      apply(q[i].s);
      exp_q.push_back(q[i].e);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL jump step=%0d got=%b expected=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    vec_t q [$];
    logic [5:0] want;
    do_reset();
    q.push_back('{s_ld(3'd1, 3'd0), E_OK});
    q.push_back('{s_alu(3'd2, 3'd4, 3'd5), E_OK});
    q.push_back('{s_halt(), E_OK});
    q.push_back('{s_nop(), E_DR});
    q.push_back('{s_nop(), E_DR});
    q.push_back('{s_nop(), E_DR});
    q.push_back('{s_nop(), E_HL});
    q.push_back('{s_alu(3'd3, 3'd4, 3'd5), E_HL});
    foreach (q[i]) begin
      apply(q[i].s);
      exp_q.push_back(q[i].e);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL halt_drain step=%0d got=%b expected=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_jump_err();
    vec_t q [$];
    logic [5:0] want;
    stim_t hj;
    do_reset();
    hj = s_halt();
    hj.jt = 1'b1;
    q.push_back('{hj, E_FL});
    q.push_back('{s_nop(), E_DR | 6'b000001});
    q.push_back('{s_nop(), E_HL | 6'b000001});
    foreach (q[i]) begin
      apply(q[i].s);
      exp_q.push_back(q[i].e);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL halt_jump_err step=%0d got=%b expected=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    vec_t q [$];
    logic [5:0] want;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      q.push_back('{with_ms(s_nop()), (k >= 16) ? (E_MS | 6'b000001) : E_MS});
    end
    q.push_back('{s_nop(), 6'b000001});
    q.push_back('{with_ms(s_nop()), E_MS | 6'b000001});
    foreach (q[i]) begin
      apply(q[i].s);
      exp_q.push_back(q[i].e);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL watchdog step=%0d got=%b expected=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
    apply(with_ms(s_nop()));
    rst_n = 1'b0;
    exp_q.push_back(E_OK);
    #2;
    want = exp_q.pop_front();
    checks++;
    if (outs !== want) begin
      failures++;
      $display("FAIL reset_mid_stall got=%b expected=%b", outs, want);
    end
    do_reset();
  endtask

  initial begin
    apply(s_nop());
    test_reset();
    test_load_use();
    test_alu_dep();
    test_branch();
    test_jump();
    test_halt();
    test_halt_jump_err();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
`default_nettype wire
